// File: rtl/crc_tx_sequencer_pkg.sv
// Shared link constants, FSM state encoding and a width helper for the CRC transmit path.
// Imported by the sequencer top level.
package crc_tx_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned LINK_POLY = 32'h07;
  localparam int unsigned LINK_DIV  = 20;

  // Bits needed to hold values 0..v-1.
  function automatic int unsigned clog2_w(input int unsigned v);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(v)) w++;
    return w;
  endfunction

endpackage

// File: rtl/crc_tx_sequencer_tick_prescaler.sv
// Modulo-DIV bit-slot prescaler: registered one-cycle Tick while the count sits at DIV-1.
// Clear holds the count at 0; counting only advances while En is high.
module tick_prescaler #(
  parameter int unsigned DIV   = 20,
  parameter int unsigned DIV_W = 5
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic En,
  output logic Tick
);

  logic [DIV_W-1:0] cnt;

  // Tick is registered from the DIV-2 count so it lines up with count DIV-1.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt  <= '0;
      Tick <= 1'b0;
    end else if (Clear) begin
      cnt  <= '0;
      Tick <= 1'b0;
    end else if (En) begin
      cnt  <= (cnt == DIV_W'(DIV - 1)) ? '0 : cnt + 1'b1;
      Tick <= (cnt == DIV_W'(DIV - 2));
    end else begin
      Tick <= 1'b0;
    end
  end

endmodule

// File: rtl/crc_tx_sequencer.sv
// Serial frame transmitter: payload MSB-first, then its serially computed CRC, one bit per DIV clocks.
// Start is taken only when Ready; Abort ends a frame in flight without a Done pulse.
module crc_tx_sequencer
  import crc_tx_sequencer_pkg::*;
#(
  parameter int unsigned      DATA_W = 8,
  parameter int unsigned      CRC_W  = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(LINK_POLY),
  parameter int unsigned      DIV    = LINK_DIV,
  parameter int unsigned      DIV_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] Data,
  input  logic              Abort,
  output logic              Ready,
  output logic              TxEn,
  output logic              TxBit,
  output logic              Busy,
  output logic              Done,
  output logic [CRC_W-1:0]  Crc
);

  localparam int unsigned SH_W  = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int unsigned CNT_W = clog2_w(SH_W + 1);

  state_t             state, state_n;
  logic [SH_W-1:0]    shift, shift_n;
  logic [CRC_W-1:0]   crc, crc_n, crc_upd, crc_out_n;
  logic [CNT_W-1:0]   bitcnt, bitcnt_n;
  logic               tx_en_n, tx_bit_n, busy_n, done_n, ready_n;
  logic               tick, in_frame;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic [CRC_W-1:0] r;
    r = c << 1;
    if (c[CRC_W-1] ^ b) r = r ^ POLY;
    return r;
  endfunction

  assign in_frame = (state == ST_DATA) || (state == ST_CRC);
  assign crc_upd  = crc_step(crc, shift[SH_W-1]);

  tick_prescaler #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_prescaler (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (!in_frame),
    .En    (in_frame),
    .Tick  (tick)
  );

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    crc_n     = crc;
    bitcnt_n  = bitcnt;
    tx_en_n   = TxEn;
    tx_bit_n  = TxBit;
    busy_n    = Busy;
    done_n    = 1'b0;
    ready_n   = Ready;
    crc_out_n = Crc;

    unique case (state)
      ST_IDLE: begin
        if (Start && Ready) begin
          state_n                    = ST_DATA;
          shift_n                    = '0;
          shift_n[SH_W-1 -: DATA_W]  = Data;
          crc_n                      = '0;
          bitcnt_n                   = '0;
          tx_en_n                    = 1'b1;
          tx_bit_n                   = Data[DATA_W-1];
          busy_n                     = 1'b1;
          ready_n                    = 1'b0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          crc_n = crc_upd;
          if (bitcnt == CNT_W'(DATA_W - 1)) begin
            // Last payload bit: the freshly updated CRC becomes the next thing on the line.
            state_n                   = ST_CRC;
            shift_n                   = '0;
            shift_n[SH_W-1 -: CRC_W]  = crc_upd;
            bitcnt_n                  = '0;
            tx_bit_n                  = crc_upd[CRC_W-1];
          end else begin
            shift_n  = shift << 1;
            bitcnt_n = bitcnt + 1'b1;
            tx_bit_n = shift[SH_W-2];
          end
        end
      end
      ST_CRC: begin
        if (tick) begin
          if (bitcnt == CNT_W'(CRC_W - 1)) begin
            state_n   = ST_DONE;
            bitcnt_n  = '0;
            tx_en_n   = 1'b0;
            tx_bit_n  = 1'b0;
            done_n    = 1'b1;
            crc_out_n = crc;
          end else begin
            shift_n  = shift << 1;
            bitcnt_n = bitcnt + 1'b1;
            tx_bit_n = shift[SH_W-2];
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        ready_n = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    // Abort wins over everything in flight, including the final CRC tick.
    if (in_frame && Abort) begin
      state_n   = ST_IDLE;
      shift_n   = shift;
      crc_n     = crc;
      bitcnt_n  = '0;
      tx_en_n   = 1'b0;
      tx_bit_n  = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      ready_n   = 1'b1;
      crc_out_n = Crc;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      shift  <= '0;
      crc    <= '0;
      bitcnt <= '0;
      TxEn   <= 1'b0;
      TxBit  <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Ready  <= 1'b1;
      Crc    <= '0;
    end else begin
      state  <= state_n;
      shift  <= shift_n;
      crc    <= crc_n;
      bitcnt <= bitcnt_n;
      TxEn   <= tx_en_n;
      TxBit  <= tx_bit_n;
      Busy   <= busy_n;
      Done   <= done_n;
      Ready  <= ready_n;
      Crc    <= crc_out_n;
    end
  end

endmodule

// File: tb/tb_crc_tx_sequencer.sv
// Bench for crc_tx_sequencer at DIV=4: table of frames (fixed and random) against a polynomial-division
// CRC model, plus hand-written abort and asynchronous-reset sequences.
module tb_crc_tx_sequencer;

  localparam int DIV   = 4;
  localparam int SLOTS = 16;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [7:0] Data;
  logic       Abort;
  logic       Ready, TxEn, TxBit, Busy, Done;
  logic [7:0] Crc;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_crc;

  typedef struct {
    logic [7:0] data;
    int         abort_slot;
    bit         retrig;
    bit         abort_at_start;
    logic [7:0] exp_crc;
  } vec_t;

  vec_t vecs[12];

  crc_tx_sequencer #(
    .DATA_W (8),
    .CRC_W  (8),
    .POLY   (8'h07),
    .DIV    (DIV),
    .DIV_W  (3)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Data  (Data),
    .Abort (Abort),
    .Ready (Ready),
    .TxEn  (TxEn),
    .TxBit (TxBit),
    .Busy  (Busy),
    .Done  (Done),
    .Crc   (Crc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Remainder of data * x^8 divided by x^8 + x^2 + x + 1.
  function automatic logic [7:0] model_crc(input logic [7:0] d);
    logic [15:0] r;
    logic [15:0] g;
    r = {d, 8'h00};
    g = 16'h0107;
    for (int i = 15; i >= 8; i--)
      if (r[i]) r = r ^ (g << (i - 8));
    return r[7:0];
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    logic [15:0] stream;
    int n_cyc, bad, first_bad, idx;
    stream = {v.data, model_crc(v.data)};
    check("ready_before_start", Ready, 1);
    check("txen_before_start", TxEn, 0);
    Start = 1'b1;
    Data  = v.data;
    Abort = v.abort_at_start;
    step();
    Start = 1'b0;
    Abort = 1'b0;
    n_cyc = (v.abort_slot >= 0) ? v.abort_slot * DIV + 2 : SLOTS * DIV;
    bad = 0;
    first_bad = -1;
    for (int c = 0; c < n_cyc; c++) begin
      idx = 15 - c / DIV;
      if (TxEn !== 1'b1 || TxBit !== stream[idx] || Done !== 1'b0 || Busy !== 1'b1 || Ready !== 1'b0) begin
        if (bad == 0) first_bad = c;
        bad++;
      end
      if (v.retrig && c == 10) begin
        Start = 1'b1;
        Data  = 8'hFF;
      end else if (v.retrig && c == 11) begin
        Start = 1'b0;
        Data  = v.data;
      end
      if (v.abort_slot >= 0 && c == n_cyc - 1) Abort = 1'b1;
      step();
      Abort = 1'b0;
    end
    if (bad != 0) $display("first bad cycle %0d of frame data 0x%0h", first_bad, v.data);
    check("serial_stream_bad_cycles", bad, 0);
    if (v.abort_slot >= 0) begin
      check("abort_txen", TxEn, 0);
      check("abort_txbit", TxBit, 0);
      check("abort_ready", Ready, 1);
      check("abort_done", Done, 0);
      check("abort_busy", Busy, 0);
      check("abort_crc_held", Crc, last_crc);
    end else begin
      check("done_pulse", Done, 1);
      check("done_txen", TxEn, 0);
      check("done_txbit", TxBit, 0);
      check("done_busy", Busy, 1);
      check("done_crc", Crc, v.exp_crc);
      last_crc = v.exp_crc;
      step();
      check("post_done_ready", Ready, 1);
      check("post_done_done_low", Done, 0);
      check("post_done_busy", Busy, 0);
      check("post_done_crc_held", Crc, v.exp_crc);
    end
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    Data  = 8'h00;
    Abort = 1'b0;
    last_crc = 8'h00;

    vecs[0] = '{8'h01, -1, 1'b0, 1'b0, 8'h07};
    vecs[1] = '{8'h31, -1, 1'b0, 1'b0, 8'h97};
    vecs[2] = '{8'h00, -1, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{8'h01, -1, 1'b1, 1'b0, 8'h07};
    vecs[4] = '{8'hA5,  3, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{8'h31, -1, 1'b0, 1'b1, 8'h97};
    for (int i = 6; i < 12; i++) begin
      vecs[i].data           = 8'($urandom);
      vecs[i].abort_slot     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SLOTS - 1)) : -1;
      vecs[i].retrig         = 1'($urandom_range(0, 1));
      vecs[i].abort_at_start = 1'($urandom_range(0, 1));
      vecs[i].exp_crc        = model_crc(vecs[i].data);
    end

    repeat (2) step();
    check("reset_ready", Ready, 1);
    check("reset_txen", TxEn, 0);
    check("reset_txbit", TxBit, 0);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_crc", Crc, 0);
    Reset = 1'b1;
    step();

    for (int i = 0; i < 12; i++) run_frame(vecs[i]);

    // Asynchronous reset in the middle of the CRC section.
    Start = 1'b1;
    Data  = 8'h5A;
    step();
    Start = 1'b0;
    repeat (8 * DIV + 5) @(posedge Clk);
    #3;
    check("precond_mid_frame_txen", TxEn, 1);
    Reset = 1'b0;
    #1;
    check("async_rst_txen", TxEn, 0);
    check("async_rst_txbit", TxBit, 0);
    check("async_rst_ready", Ready, 1);
    check("async_rst_busy", Busy, 0);
    check("async_rst_done", Done, 0);
    check("async_rst_crc", Crc, 0);
    #3;
    Reset = 1'b1;
    last_crc = 8'h00;
    repeat (2) step();
    check("post_rst_ready", Ready, 1);
    check("post_rst_txen", TxEn, 0);
    run_frame(vecs[1]);
    run_frame(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_tx_sequencer.md
Name: crc_tx_sequencer

Overview:
Serial transmit controller for the CRC network link. It accepts one parallel data word per frame through a start/ready handshake. It shifts the word out MSB-first at a programmable bit-slot rate, then appends a serially computed CRC, MSB-first. Bit timing comes from an internal modulo-DIV prescaler. Sits between the packet-assembly logic and the line driver.

Parameters:
DATA_W, 8, payload bits per frame
CRC_W, 8, CRC width in bits
POLY, 8'h07, CRC generator polynomial; implicit x^CRC_W term; CRC_W bits wide
DIV, 20, clocks per bit slot; legal range >= 2
DIV_W, 5, prescaler counter width; must satisfy 2^DIV_W >= DIV

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  frame request; accepted only when Ready=1
Data  input  DATA_W  payload; sampled on the accepted Start cycle
Abort  input  1  synchronous frame abort
Ready  output  1  high in IDLE only
TxEn  output  1  high during every payload and CRC bit slot
TxBit  output  1  current serial bit; 0 whenever TxEn=0
Busy  output  1  high from the cycle after acceptance until return to IDLE
Done  output  1  one-cycle pulse on normal frame completion
Crc  output  CRC_W  final CRC; valid from Done until the next acceptance

Behaviour:
- Clock and reset: one clock (Clk); asynchronous active-low reset (Reset).
- Reset values:
  - FSM=IDLE, Ready=1, TxEn=0, TxBit=0, Busy=0, Done=0.
  - Crc=0, shift register=0, prescaler=0, bit counter=0.
- All outputs are registered.
- FSM states: IDLE, DATA, CRC, DONE.
- IDLE -> DATA when Start=1 and Ready=1. On that edge:
  - Data is latched into the shift register.
  - CRC register is cleared to 0.
  - Prescaler and bit counter are cleared.
- First bit timing: the first payload bit (Data[DATA_W-1]) appears on TxBit with TxEn=1 one clock after the acceptance edge.
- Bit slots:
  - Each slot lasts exactly DIV clocks.
  - The prescaler counts 0..DIV-1 and asserts a tick at count DIV-1, then wraps to 0.
  - On a tick the shift register shifts left and the bit counter increments.
- CRC update, applied once per transmitted payload bit on its tick:
  - fb = crc[CRC_W-1] XOR bit.
  - crc = (crc << 1) XOR (fb ? POLY : 0), truncated to CRC_W bits.
- DATA -> CRC on the tick of payload bit DATA_W-1. The CRC register is loaded into the shift register. The CRC is not updated during the CRC state.
- CRC -> DONE on the tick of CRC bit CRC_W-1.
- DONE state:
  - Lasts one cycle: Done=1, TxEn=0, Busy=1.
  - Crc output is loaded with the final CRC.
  - Next state is IDLE.
- Frame duration: TxEn is high for exactly (DATA_W+CRC_W)*DIV consecutive clocks. Acceptance to Done takes (DATA_W+CRC_W)*DIV+1 clocks.
- Start while Busy=1 is ignored. It is not queued.
- Abort=1 in DATA or CRC:
  - Next state is IDLE.
  - TxEn=0 and TxBit=0 on the next clock.
  - No Done pulse; Crc output is unchanged.
- Abort in IDLE or DONE has no effect.
- Abort and Start in the same IDLE cycle: the Start is accepted; Abort is ignored.
- Asynchronous reset asserted mid-frame forces all reset values immediately. No partial frame resumes after reset release.
- Back-to-back frames: a Start asserted in the IDLE cycle following DONE is accepted. Minimum frame-to-frame gap is 2 clocks of TxEn=0.
- Bit counter width: clog2(max(DATA_W,CRC_W)+1). It wraps to 0 on each state change.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, DATA=2'd1, CRC=2'd2, DONE=2'd3).
  - Default POLY and DIV constants for the link.
  - A clog2 width helper.
- One sub-module: tick_prescaler.
  - Parameters: DIV, DIV_W.
  - Inputs: Clk, Reset, Clear, En.
  - Output: registered single-cycle Tick at count DIV-1.
  - The FSM, shift register and CRC logic stay in the top level.

Test Plan:
- DIV=4, Data=8'h01, Start pulse. TxBit serial sequence is 0000_0001 then 0000_0111 (Crc=8'h07). Each bit holds 4 clocks; TxEn high 64 clocks; Done pulses once; Ready returns high the next cycle.
- DIV=4, Data=8'h31. Payload bits 0011_0001, then CRC 1001_0111. Crc=8'h97 at Done.
- DIV=4, Data=8'h00. All 16 slots TxBit=0; Crc=8'h00; Done asserted at clock 65 after acceptance.
- Start re-pulsed with Data=8'hFF during DATA of a frame carrying 8'h01. The second Start is ignored; output and Crc=8'h07 match the undisturbed frame.
- Abort asserted in payload bit 3. Next clock: TxEn=0, TxBit=0, Ready=1, no Done, Crc holds its previous value. A fresh Start then sends a correct full frame.
- Reset driven low mid CRC state, asynchronous to Clk. All outputs take reset values before the next edge. After release: Ready=1, and the next frame is correct.
